// File: rtl/regfile_pkg.sv
// Shared defaults and types for the regfile_sb register file.
// The optional same-cycle write bypass is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] data_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one set/clear flag per register plus two lookup ports.
// With REGFILE_BYPASS_EN defined, a same-cycle write masks the looked-up busy flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  input  logic          w0_en,
  input  logic [AW-1:0] w0_addr,
  input  logic          w1_en,
  input  logic [AW-1:0] w1_addr,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr,
  input  logic          flush
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW-1:0]    w_rd_addr [2];
  logic             w_rd_busy [2];

  // Priority, lowest to highest: write clears, alloc sets, flush clears all.
  always_comb begin
    // NOTE: the default assignment first means every path drives w_busy_nxt, so no latch is inferred.
    w_busy_nxt = r_busy;
    if (w0_en)    w_busy_nxt[w0_addr]    = 1'b0;
    if (w1_en)    w_busy_nxt[w1_addr]    = 1'b0;
    if (alloc_en) w_busy_nxt[alloc_addr] = 1'b1;
    if (flush)    w_busy_nxt             = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign w_rd_addr[0] = rs1_addr;
  assign w_rd_addr[1] = rs2_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_busy[p] = r_busy[w_rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (w_rd_addr[p] != '0 &&
          ((w0_en && w0_addr == w_rd_addr[p]) || (w1_en && w1_addr == w_rd_addr[p])) &&
          !(alloc_en && alloc_addr == w_rd_addr[p]))
        w_rd_busy[p] = 1'b0;
`endif
    end
  end

  assign rs1_busy = w_rd_busy[0];
  assign rs2_busy = w_rd_busy[1];

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with integrated busy-bit scoreboard; x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            w0_en,
  input  logic [AW-1:0]   w0_addr,
  input  logic [XLEN-1:0] w0_data,
  input  logic            w1_en,
  input  logic [AW-1:0]   w1_addr,
  input  logic [XLEN-1:0] w1_data,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            flush
);

  logic [XLEN-1:0] r_regs    [NREGS];
  logic [AW-1:0]   w_rd_addr [2];
  logic [XLEN-1:0] w_rd_data [2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the array is reset because every read must return 0 during and after reset; this keeps it in flops.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments; the later w0 statement wins when both ports hit one address.
      if (w1_en && w1_addr != '0) r_regs[w1_addr] <= w1_data;
      if (w0_en && w0_addr != '0) r_regs[w0_addr] <= w0_data;
    end
  end

  assign w_rd_addr[0] = rs1_addr;
  assign w_rd_addr[1] = rs2_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_data[p] = r_regs[w_rd_addr[p]];
      if (w_rd_addr[p] == '0) begin
        w_rd_data[p] = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (w0_en && w0_addr == w_rd_addr[p]) begin
        w_rd_data[p] = w0_data;
      end else if (w1_en && w1_addr == w_rd_addr[p]) begin
        w_rd_data[p] = w1_data;
      end
`endif
    end
  end

  assign rs1_data = w_rd_data[0];
  assign rs2_data = w_rd_data[1];

  regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk        (clk),
    .rstn       (rstn),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .w0_en      (w0_en),
    .w0_addr    (w0_addr),
    .w1_en      (w1_en),
    .w1_addr    (w1_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed test-plan cases with literal expectations,
// then randomized traffic compared every cycle against an array-based model.
module tb_regfile_sb;

  logic        clk;
  logic        rstn;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        w0_en, w1_en;
  logic [4:0]  w0_addr, w1_addr;
  logic [31:0] w0_data, w1_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile_sb dut (
    .clk        (clk),
    .rstn       (rstn),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .w0_en      (w0_en),
    .w0_addr    (w0_addr),
    .w0_data    (w0_data),
    .w1_en      (w1_en),
    .w1_addr    (w1_addr),
    .w1_data    (w1_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    logic [31:0] d;
    d = (a == 0) ? 32'h0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0) begin
      if (w1_en && w1_addr == a) d = w1_data;
      if (w0_en && w0_addr == a) d = w0_data;
    end
`endif
    return d;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic b;
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0 && ((w0_en && w0_addr == a) || (w1_en && w1_addr == a)) &&
        !(alloc_en && alloc_addr == a))
      b = 1'b0;
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Applies the architectural rules in order: data writes (w0 last so it wins), busy clears,
  // alloc set, flush, and x0 pinned.
  task automatic model_update();
    if (w1_en) begin m_regs[w1_addr] = w1_data; m_busy[w1_addr] = 1'b0; end
    if (w0_en) begin m_regs[w0_addr] = w0_data; m_busy[w0_addr] = 1'b0; end
    if (alloc_en) m_busy[alloc_addr] = 1'b1;
    if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_regs[0] = 32'h0;
    m_busy[0] = 1'b0;
  endtask

  task automatic compare_model();
    check("model rs1_data", rs1_data, exp_data(rs1_addr));
    check("model rs2_data", rs2_data, exp_data(rs2_addr));
    check("model rs1_busy", {31'h0, rs1_busy}, {31'h0, exp_busy(rs1_addr)});
    check("model rs2_busy", {31'h0, rs2_busy}, {31'h0, exp_busy(rs2_addr)});
  endtask

  task automatic step();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    w0_en = 0; w0_addr = 0; w0_data = 0;
    w1_en = 0; w1_addr = 0; w1_data = 0;
    alloc_en = 0; alloc_addr = 0; flush = 0;
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rstn = 1'b0;
    idle();
    rs1_addr = 0;
    rs2_addr = 0;
    model_reset();

    // Reset held: every address reads 0, not busy.
    repeat (2) @(posedge clk);
    #2;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      check("reset rs1_data", rs1_data, 32'h0);
      check("reset rs2_data", rs2_data, 32'h0);
      check("reset rs1_busy", {31'h0, rs1_busy}, 32'h0);
      check("reset rs2_busy", {31'h0, rs2_busy}, 32'h0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // x0 ignores writes and allocs.
    w0_en = 1; w0_addr = 0; w0_data = 32'hDEADBEEF;
    alloc_en = 1; alloc_addr = 0;
    rs1_addr = 0; rs2_addr = 0;
    step();
    idle();
    #1;
    check("x0 data", rs1_data, 32'h0);
    check("x0 busy", {31'h0, rs1_busy}, 32'h0);

    // Dual write conflict: w0 wins.
    w0_en = 1; w0_addr = 5; w0_data = 32'h11;
    w1_en = 1; w1_addr = 5; w1_data = 32'h22;
    step();
    idle();
    w1_en = 1; w1_addr = 6; w1_data = 32'h33;
    step();
    idle();
    rs1_addr = 5; rs2_addr = 6;
    #1;
    check("conflict x5", rs1_data, 32'h11);
    check("conflict x6", rs2_data, 32'h33);

    // RAW: busy from alloc until the write edge.
    alloc_en = 1; alloc_addr = 7;
    step();
    idle();
    rs1_addr = 7;
    #1;
    check("raw busy after alloc", {31'h0, rs1_busy}, 32'h1);
    w0_en = 1; w0_addr = 7; w0_data = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("raw busy during write", {31'h0, rs1_busy}, 32'h0);
`else
    check("raw busy during write", {31'h0, rs1_busy}, 32'h1);
`endif
    step();
    idle();
    #1;
    check("raw busy after write", {31'h0, rs1_busy}, 32'h0);
    check("raw data after write", rs1_data, 32'h55);

    // Alloc/write collision: alloc wins, data still written.
    alloc_en = 1; alloc_addr = 9;
    step();
    idle();
    w1_en = 1; w1_addr = 9; w1_data = 32'hAA;
    alloc_en = 1; alloc_addr = 9;
    step();
    idle();
    rs1_addr = 9;
    #1;
    check("collision data", rs1_data, 32'hAA);
    check("collision busy", {31'h0, rs1_busy}, 32'h1);

    // Flush clears everything, including a same-cycle alloc.
    foreach (m_busy[i]) ;
    alloc_en = 1; alloc_addr = 3;  step();
    alloc_en = 1; alloc_addr = 4;  step();
    alloc_en = 1; alloc_addr = 31; step();
    idle();
    rs1_addr = 31;
    #1;
    check("pre-flush x31 busy", {31'h0, rs1_busy}, 32'h1);
    flush = 1; alloc_en = 1; alloc_addr = 8;
    step();
    idle();
    rs1_addr = 3; rs2_addr = 31;
    #1;
    check("flush x3 busy", {31'h0, rs1_busy}, 32'h0);
    check("flush x31 busy", {31'h0, rs2_busy}, 32'h0);
    rs1_addr = 4; rs2_addr = 8;
    #1;
    check("flush x4 busy", {31'h0, rs1_busy}, 32'h0);
    check("flush x8 busy", {31'h0, rs2_busy}, 32'h0);
    check("flush x9 busy", {31'h0, m_busy[9] ? 1'b0 : 1'b1}, 32'h1);

    // Bypass: x10 holds 0x77 and is busy, then written with 0x1234 while read.
    w0_en = 1; w0_addr = 10; w0_data = 32'h77; step();
    idle();
    alloc_en = 1; alloc_addr = 10; step();
    idle();
    w0_en = 1; w0_addr = 10; w0_data = 32'h1234;
    rs1_addr = 10;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass data", rs1_data, 32'h1234);
    check("bypass busy", {31'h0, rs1_busy}, 32'h0);
`else
    check("bypass data", rs1_data, 32'h77);
    check("bypass busy", {31'h0, rs1_busy}, 32'h1);
`endif
    step();
    idle();
    #1;
    check("bypass data next cycle", rs1_data, 32'h1234);

    // Randomized traffic with occasional asynchronous reset mid-cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      w0_en      = ($urandom_range(0, 1) == 1);
      w0_addr    = rnd_addr();
      w0_data    = $urandom;
      w1_en      = ($urandom_range(0, 1) == 1);
      w1_addr    = rnd_addr();
      w1_data    = $urandom;
      alloc_en   = ($urandom_range(0, 2) != 0);
      alloc_addr = rnd_addr();
      flush      = ($urandom_range(0, 24) == 0);
      rs1_addr   = rnd_addr();
      rs2_addr   = rnd_addr();
      if (cyc % 700 == 350) begin
        rstn = 1'b0;
        #1;
        check("async reset rs1_data", rs1_data, 32'h0);
        check("async reset rs1_busy", {31'h0, rs1_busy}, 32'h0);
        model_reset();
        rstn = 1'b1;
        #1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
